fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the `control` decoder. Owns the program counter, issues word-aligned requests to instruction memory over a valid/ready channel, and buffers in-order responses in a small FIFO. Presents the head instruction with its PC and pre-sliced `opcode`/`func3`/`func7` fields to decode. Accepts redirects from branch/jump resolution (`jal`, `jalr`, `beq`…`bgeu`), flushing buffered and in-flight instructions.

---
 rtl/fetch_unit_pkg.sv | 28 ++
 rtl/fetch_fifo.sv | 74 +++++++
 rtl/fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_fetch_unit.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: constants and types shared by the fetch stage.
//   RESET_PC_DEFAULT   default program counter after reset
//   NOP_INST           instruction presented to decode when nothing is buffered
//   *_LSB/*_MSB/*_BIT  instruction field positions, identical to the decoder's
//   fetch_entry_t      one buffered instruction: {pc, word}
//   align_word()       clears the byte-offset bits of an address
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;  // addi x0, x0, 0

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int FUNC3_LSB  = 12;
  localparam int FUNC3_MSB  = 14;
  localparam int FUNC7_BIT  = 30;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

  // Masking (rather than slicing) keeps every input bit referenced.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with flush.
//   clk, rst_n      clock and asynchronous active-low reset
//   flush           empties the FIFO; overrides push and pop in the same cycle
//   push/push_data  write one entry (ignored when full)
//   pop             discard the head entry (ignored when empty)
//   head_data       current head entry (combinational read, valid when !empty)
//   full/empty      occupancy flags
//   count           number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap on their own.
module fetch_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (do_push && !do_pop) begin
        count_reg <= count_reg + CW'(1);
      end else if (!do_push && do_pop) begin
        count_reg <= count_reg - CW'(1);
      end
    end
  end

  assign head_data = mem_reg[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
//   clk, rst_n                    clock, asynchronous active-low reset
//   imem_req_valid/ready/addr     word-aligned fetch requests
//   imem_rsp_valid/data           in-order responses, no backpressure
//   redirect_valid/redirect_pc    single-cycle PC override from branch resolution
//   inst_valid/inst_ready         head instruction handshake with decode
//   inst, inst_pc                 head word and its PC (NOP / 0 when empty)
//   opcode, func3, func7          fields sliced from inst
// Requests are capped so that in-flight plus buffered never exceeds DEPTH,
// which is what guarantees the instruction FIFO can always take a response.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic        func7
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;

  logic [31:0]   pc_reg;
  logic [31:0]   pc_next;
  logic [CW-1:0] inflight_reg;
  logic [CW-1:0] inflight_next;
  logic [CW-1:0] drop_reg;
  logic [CW-1:0] drop_next;

  logic          accept;
  logic          rsp_drop;
  logic          rsp_live;
  logic          consume;
  logic [SW-1:0] outstanding;

  logic [31:0]   tag_pc;
  logic          tag_full;
  logic          tag_empty;
  logic [CW-1:0] tag_count;

  fetch_entry_t  inst_head;
  logic          inst_full;
  logic          inst_empty;
  logic [CW-1:0] inst_count;

  // Request channel: derived from state only. rst_n gating holds the request
  // low during reset and lets the first one go out in the cycle reset lifts.
  assign outstanding    = SW'(inflight_reg) + SW'(inst_count);
  assign imem_req_valid = rst_n && (outstanding < SW'(DEPTH));
  assign imem_req_addr  = pc_reg;

  assign accept   = imem_req_valid && imem_req_ready;
  assign rsp_drop = imem_rsp_valid && (drop_reg != '0);
  assign rsp_live = imem_rsp_valid && (drop_reg == '0);
  assign consume  = inst_valid && inst_ready;

  always_comb begin
    inflight_next = inflight_reg;
    if (accept && !imem_rsp_valid) begin
      inflight_next = inflight_reg + CW'(1);
    end else if (!accept && imem_rsp_valid) begin
      inflight_next = inflight_reg - CW'(1);
    end

    // On redirect everything still outstanding (including a request accepted
    // this very cycle) becomes stale; a response landing this cycle is already
    // excluded from inflight_next, so it is not counted twice.
    drop_next = drop_reg;
    if (redirect_valid) begin
      drop_next = inflight_next;
    end else if (rsp_drop) begin
      drop_next = drop_reg - CW'(1);
    end

    pc_next = pc_reg;
    if (redirect_valid) begin
      pc_next = align_word(redirect_pc);
    end else if (accept) begin
      pc_next = pc_reg + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg       <= align_word(RESET_PC);
      inflight_reg <= '0;
      drop_reg     <= '0;
    end else begin
      pc_reg       <= pc_next;
      inflight_reg <= inflight_next;
      drop_reg     <= drop_next;
    end
  end

  // PC tags of live in-flight requests; stale responses never pop it because
  // their tags were discarded by the redirect flush.
  fetch_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (accept),
    .push_data (pc_reg),
    .pop       (rsp_live),
    .head_data (tag_pc),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_inst_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (rsp_live),
    .push_data ({tag_pc, imem_rsp_data}),
    .pop       (consume),
    .head_data (inst_head),
    .full      (inst_full),
    .empty     (inst_empty),
    .count     (inst_count)
  );

  assign inst_valid = !inst_empty;
  assign inst       = inst_valid ? inst_head.word : NOP_INST;
  assign inst_pc    = inst_valid ? inst_head.pc : 32'h0;
  assign opcode     = inst[OPCODE_MSB:OPCODE_LSB];
  assign func3      = inst[FUNC3_MSB:FUNC3_LSB];
  assign func7      = inst[FUNC7_BIT];

  // Structural invariants of the issue cap and drop bookkeeping.
  a_inst_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(rsp_live && inst_full));
  a_tag_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(accept && tag_full));
  a_tag_present: assert property (@(posedge clk) disable iff (!rst_n)
    !(rsp_live && tag_empty));
  a_tag_matches_live: assert property (@(posedge clk) disable iff (!rst_n)
    tag_count == (inflight_reg - drop_reg));
  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rsp_valid && (inflight_reg == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        func7;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (RST_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .opcode         (opcode),
    .func3          (func3),
    .func7          (func7)
  );

  // Memory-side view: every accepted request, whether its word is still wanted,
  // and the cycle its response becomes due.
  typedef struct {
    logic [31:0] addr;
    bit          live;
    int          due;
  } mreq_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  mreq_t       mem_q[$];
  exp_t        exp_q[$];      // scoreboard: instructions decode should see, in order
  logic [31:0] acc_log[$];    // addresses accepted (outside redirect cycles)
  logic [31:0] deliv_log[$];  // PCs delivered to decode
  int          occ = 0;       // words delivered by memory, still wanted, not consumed
  logic [31:0] model_pc = RST_PC;
  int          cyc = 0;
  int          lat_min = 1, lat_max = 1, ready_pct = 100, irdy_pct = 100;
  int          n_cmp = 0, n_bad = 0;

  function automatic logic [31:0] word_for(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: required event not observed (t=%0t)", name, $time);
  endtask

  // Monitor: pops the scoreboard whenever decode takes an instruction.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (inst_valid && inst_ready && !redirect_valid) begin
        deliv_log.push_back(inst_pc);
        if (exp_q.size() == 0) begin
          fail("unexpected_inst");
        end else begin
          e = exp_q.pop_front();
          check("inst_pc", inst_pc, e.pc);
          check("inst_word", inst, e.word);
          check("inst_fields", {21'd0, opcode, func3, func7},
                {21'd0, e.word[6:0], e.word[14:12], e.word[30]});
          $display("inst pc=%h word=%h", inst_pc, inst);
        end
      end else if (!inst_valid) begin
        check("empty_inst", inst, NOP);
        check("empty_pc", inst_pc, 32'h0);
      end
    end
  end

  // Reference model: request cap, expected address and instruction stream.
  always @(negedge clk) begin
    mreq_t r;
    bit    acc;
    int    lat;
    #1;
    if (!rst_n) begin
      mem_q.delete();
      exp_q.delete();
      occ      = 0;
      model_pc = RST_PC;
    end else begin
      check_bit("req_valid", imem_req_valid, (mem_q.size() + occ) < DEPTH);
      if (imem_req_valid) check("req_addr", imem_req_addr, model_pc);
      check_bit("inst_valid", inst_valid, occ > 0);
      acc = imem_req_valid && imem_req_ready;
      if (imem_rsp_valid && mem_q.size() > 0) begin
        r = mem_q.pop_front();
        if (r.live && !redirect_valid) occ++;
      end
      if (inst_valid && inst_ready && !redirect_valid && occ > 0) occ--;
      if (acc) begin
        lat = $urandom_range(lat_max, lat_min);
        mem_q.push_back('{model_pc, !redirect_valid, cyc + lat});
        if (!redirect_valid) begin
          exp_q.push_back('{model_pc, word_for(model_pc)});
          acc_log.push_back(imem_req_addr);
        end
      end
      if (redirect_valid) begin
        foreach (mem_q[i]) mem_q[i].live = 1'b0;
        occ = 0;
        exp_q.delete();
        model_pc = redirect_pc & ~32'h3;
      end else if (acc) begin
        model_pc = model_pc + 32'd4;
      end
    end
  end

  // One clock of stimulus: memory response, random ready, no redirect.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    redirect_valid = 1'b0;
    imem_req_ready = ($urandom_range(99) < ready_pct);
    inst_ready     = ($urandom_range(99) < irdy_pct);
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_for(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    acc_log.delete();
    deliv_log.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check_bit({tag, "_req_valid"}, imem_req_valid, 1'b0);
    check({tag, "_req_addr"}, imem_req_addr, RST_PC);
    check_bit({tag, "_inst_valid"}, inst_valid, 1'b0);
    check({tag, "_inst"}, inst, NOP);
    check({tag, "_inst_pc"}, inst_pc, 32'h0);
    check({tag, "_opcode"}, {25'd0, opcode}, 32'h13);
    check({tag, "_func3"}, {29'd0, func3}, 32'h0);
    check_bit({tag, "_func7"}, func7, 1'b0);
  endtask

  initial begin
    int  guard;
    int  n_acc0;
    bit  found;
    bit  last_redir;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;

    #1 rst_n = 1'b0;
    #1 check_reset_state("reset");
    run(2);
    rst_n = 1'b1;
    acc_log.delete();
    deliv_log.delete();

    // Streaming from the reset PC.
    run(12);
    if (acc_log.size() >= 3) begin
      check("stream_addr0", acc_log[0], 32'h100);
      check("stream_addr1", acc_log[1], 32'h104);
      check("stream_addr2", acc_log[2], 32'h108);
    end else fail("stream_addrs");
    if (deliv_log.size() >= 2) begin
      check("stream_pc0", deliv_log[0], 32'h100);
      check("stream_pc1", deliv_log[1], 32'h104);
    end else fail("stream_delivery");

    // Decode stall: issue must stop once DEPTH words are owed.
    irdy_pct = 0;
    n_acc0 = acc_log.size();
    run(10);
    check_bit("stall_req_valid", imem_req_valid, 1'b0);
    check_bit("stall_inst_valid", inst_valid, 1'b1);
    check_bit("stall_issue_cap", (acc_log.size() - n_acc0) <= DEPTH, 1'b1);
    irdy_pct = 100;
    run(10);

    // Redirect with two requests outstanding.
    lat_min = 3;
    lat_max = 3;
    guard = 0;
    step();
    while (mem_q.size() != 2 && guard < 50) begin
      step();
      guard++;
    end
    if (mem_q.size() != 2) fail("two_in_flight");
    do_redirect(32'h0000_2003);
    run(15);
    if (acc_log.size() > 0 && deliv_log.size() > 0) begin
      check("redir_addr", acc_log[0], 32'h2000);
      check("redir_first_pc", deliv_log[0], 32'h2000);
    end else fail("redir_restart");

    // Redirect coinciding with an acceptance and a response.
    lat_min = 1;
    lat_max = 1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      if (imem_req_valid && imem_rsp_valid) found = 1'b1;
    end
    if (found) begin
      do_redirect(32'h0000_3000);
      run(10);
      if (acc_log.size() > 0 && deliv_log.size() > 0) begin
        check("coinc_addr", acc_log[0], 32'h3000);
        check("coinc_first_pc", deliv_log[0], 32'h3000);
      end else fail("coinc_restart");
    end else fail("coinc_setup");

    // PC wrap-around.
    step();
    do_redirect(32'hFFFF_FFFC);
    run(10);
    if (acc_log.size() > 1 && deliv_log.size() > 1) begin
      check("wrap_addr0", acc_log[0], 32'hFFFF_FFFC);
      check("wrap_addr1", acc_log[1], 32'h0000_0000);
      check("wrap_pc1", deliv_log[1], 32'h0000_0000);
    end else fail("wrap_sequence");

    // Randomised traffic with occasional redirects.
    ready_pct = 70;
    irdy_pct  = 60;
    lat_min   = 1;
    lat_max   = 4;
    last_redir = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      step();
      if (!last_redir && $urandom_range(99) < 3) begin
        do_redirect($urandom);
        last_redir = 1'b1;
      end else begin
        last_redir = 1'b0;
      end
    end

    // Reset asserted while the FIFO is full.
    ready_pct = 100;
    irdy_pct  = 0;
    lat_min   = 1;
    lat_max   = 1;
    guard = 0;
    step();
    while (!(inst_valid && occ == DEPTH) && guard < 50) begin
      step();
      guard++;
    end
    check_bit("full_before_reset", inst_valid && (occ == DEPTH), 1'b1);
    rst_n = 1'b0;
    #1 check_reset_state("midreset");
    run(2);
    rst_n = 1'b1;
    irdy_pct = 100;
    acc_log.delete();
    deliv_log.delete();
    run(6);
    if (acc_log.size() > 0) check("post_reset_addr", acc_log[0], RST_PC);
    else fail("post_reset_issue");

    run(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

endmodule
